// File: rtl/anu_pkg.sv
// Shared encodings for the data-memory bridge. The core's control decode reuses
// the access-size constants defined here.
package anu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } bridge_state_e;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic logic size_is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/anu_lane_align.sv
// Byte-lane steering between the core's right-justified data and the 32-bit bus.
// Purely combinational; the caller chooses which address offset to present.
module anu_lane_align
  import anu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_shift,
  output logic        misaligned
);

  always_comb begin
    wstrb      = 4'b1111;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    if (size_is_word(size)) begin
      misaligned = |addr_lo;
    end else if (size == SZ_HALF) begin
      wstrb      = 4'b0011 << addr_lo;
      wdata_rep  = {2{wdata[15:0]}};
      misaligned = addr_lo[0];
    end else begin
      wstrb      = 4'b0001 << addr_lo;
      wdata_rep  = {4{wdata[7:0]}};
    end
  end

  // Upper lanes fill with zero; the core's extender picks the width it needs.
  assign rdata_shift = rdata >> {addr_lo, 3'b000};

endmodule

// File: rtl/anu_dmem_bridge.sv
// Load/store bridge from the single-cycle core's data port to a valid/ready
// memory bus; stalls the core until the access completes, aborts, or faults.
module anu_dmem_bridge
  import anu_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_ld,
  input  logic        req_st,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  bridge_state_e state;
  logic [31:0]   to_cnt;
  logic [1:0]    addr_lo;

  logic          req_any;
  logic          is_st;
  logic          done_now;
  logic          to_hit;
  logic [1:0]    al_addr;
  logic [3:0]    al_wstrb;
  logic [31:0]   al_wdata;
  logic [31:0]   al_rdata;
  logic          misaligned;

  assign req_any = req_ld | req_st;
  assign is_st   = req_st & ~req_ld;

  // Live request offset while idle; the latched offset once the access is in flight.
  assign al_addr = (state == ST_IDLE) ? req_addr[1:0] : addr_lo;

  anu_lane_align u_align (
    .size        (req_size),
    .addr_lo     (al_addr),
    .wdata       (req_wdata),
    .rdata       (bus_rdata),
    .wstrb       (al_wstrb),
    .wdata_rep   (al_wdata),
    .rdata_shift (al_rdata),
    .misaligned  (misaligned)
  );

  assign done_now = ((state == ST_REQ) && bus_ready && bus_rvalid) ||
                    ((state == ST_WAIT) && bus_rvalid);
  assign to_hit   = (TIMEOUT != 0) && (to_cnt >= 32'(TIMEOUT - 1));

  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: stall = req_any & ~misaligned;
        ST_REQ:  stall = 1'b1;
        ST_WAIT: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= RESET_ADDR;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      to_cnt    <= '0;
      addr_lo   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_any && misaligned) begin
            err <= 1'b1;
          end else if (req_any) begin
            bus_valid <= 1'b1;
            bus_we    <= is_st;
            bus_addr  <= {req_addr[31:2], 2'b00};
            bus_wdata <= is_st ? al_wdata : 32'h0;
            bus_wstrb <= is_st ? al_wstrb : 4'b0000;
            addr_lo   <= req_addr[1:0];
            to_cnt    <= '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          // A response in the same cycle as the deadline still counts as success.
          if (done_now) begin
            bus_valid <= 1'b0;
            if (!bus_we) rdata <= al_rdata;
            state <= ST_DONE;
          end else if (to_hit) begin
            bus_valid <= 1'b0;
            err       <= 1'b1;
            state     <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
            if ((state == ST_REQ) && bus_ready) begin
              bus_valid <= 1'b0;
              state     <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          // The core retires here; its request is still visible and must not relaunch.
          bus_we    <= 1'b0;
          bus_addr  <= RESET_ADDR;
          bus_wdata <= '0;
          bus_wstrb <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
